simon_round_ctrl: RTL and testbench

Iterative SIMON 32/64 sequencer between the UART command FSM and the result path. It latches the key and text byte arrays on `start`, then expands the key schedule into an internal 32-entry round-key store. It runs 32 rounds, one per clock, in encrypt or decrypt order. It presents the 4-byte result with a level `result_ready` that the command FSM polls in its wait state.

---
 rtl/simon_round_ctrl_if.sv | 20 ++
 rtl/simon_round_ctrl.sv | 136 +++++++++++++
 tb/tb_simon_round_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/simon_round_ctrl_if.sv
// Bus between the UART command FSM (master) and the SIMON 32/64 sequencer (slave).
interface simon_round_ctrl_if;
    logic       start;
    logic       cryp_decryp;
    logic [7:0] k_in      [0:7];
    logic [7:0] text_in   [0:3];
    logic [7:0] crypt_out [0:3];
    logic       result_ready;
    logic       busy;

    modport master (
        output start, cryp_decryp, k_in, text_in,
        input  crypt_out, result_ready, busy
    );

    modport slave (
        input  start, cryp_decryp, k_in, text_in,
        output crypt_out, result_ready, busy
    );
endinterface

// File: rtl/simon_round_ctrl.sv
// Iterative SIMON 32/64 sequencer: latch key/text on start, expand the key
// schedule over 28 cycles, then run 32 rounds, one per clock, in encrypt or
// decrypt order. Decrypt reuses the encrypt datapath by swapping the words on
// load and on unload and walking the round keys backwards.
module simon_round_ctrl (
    input  logic               clk,
    input  logic               reset,
    simon_round_ctrl_if.slave  bus
);

    // z0 sequence, bit i counted from the left is used by expansion step i
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ROUND,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        enc;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] key_store [0:31];
    logic [7:0]  crypt_out_r [0:3];
    logic        result_ready_r;
    logic        busy_r;

    logic        accept;
    logic [15:0] k0, k1, k2, k3;
    logic [15:0] tx, ty;
    logic [15:0] tk0, tk1, tk3;
    logic [15:0] t;
    logic        z_bit;
    logic [15:0] new_key;
    logic [15:0] round_key;
    logic [15:0] f_x;
    logic [15:0] x_next;
    logic [31:0] out_word;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    assign k3 = {bus.k_in[0], bus.k_in[1]};
    assign k2 = {bus.k_in[2], bus.k_in[3]};
    assign k1 = {bus.k_in[4], bus.k_in[5]};
    assign k0 = {bus.k_in[6], bus.k_in[7]};
    assign tx = {bus.text_in[0], bus.text_in[1]};
    assign ty = {bus.text_in[2], bus.text_in[3]};

    // Key-schedule step and round function, both indexed by the shared counter
    always_comb begin
        tk0       = key_store[cnt];
        tk1       = key_store[cnt + 5'd1];
        tk3       = key_store[cnt + 5'd3];
        t         = {tk3[2:0], tk3[15:3]} ^ tk1;
        z_bit     = Z0[6'd61 - {1'b0, cnt}];
        new_key   = 16'hFFFC ^ tk0 ^ t ^ {t[0], t[15:1]} ^ {15'd0, z_bit};
        round_key = enc ? key_store[cnt] : key_store[~cnt];
        f_x       = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
        x_next    = y ^ f_x ^ round_key;
        out_word  = enc ? {x_next, x} : {x, x_next};
    end

    // Round-key store: seeded with the user key on start, extended during EXPAND
    always_ff @(posedge clk) begin
        if (accept) begin
            key_store[0] <= k0;
            key_store[1] <= k1;
            key_store[2] <= k2;
            key_store[3] <= k3;
        end else if (state == EXPAND) begin
            key_store[cnt + 5'd4] <= new_key;
        end
    end

    // Sequencer FSM with registered status flags, state words and result bytes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            enc            <= 1'b0;
            x              <= 16'h0000;
            y              <= 16'h0000;
            result_ready_r <= 1'b0;
            busy_r         <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                crypt_out_r[b] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= EXPAND;
                        cnt            <= 5'd0;
                        enc            <= bus.cryp_decryp;
                        x              <= bus.cryp_decryp ? tx : ty;
                        y              <= bus.cryp_decryp ? ty : tx;
                        result_ready_r <= 1'b0;
                        busy_r         <= 1'b1;
                    end
                end
                EXPAND: begin
                    if (cnt == 5'd27) begin
                        cnt   <= 5'd0;
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ROUND: begin
                    x <= x_next;
                    y <= x;
                    if (cnt == 5'd31) begin
                        state          <= DONE;
                        result_ready_r <= 1'b1;
                        busy_r         <= 1'b0;
                        crypt_out_r[0] <= out_word[31:24];
                        crypt_out_r[1] <= out_word[23:16];
                        crypt_out_r[2] <= out_word[15:8];
                        crypt_out_r[3] <= out_word[7:0];
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.crypt_out    = crypt_out_r;
    assign bus.result_ready = result_ready_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl: the stimulus process queues the
// reference-model result for every accepted start, and a monitor pops and
// compares whenever result_ready rises.
module tb_simon_round_ctrl;

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [63:0] TV_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] TV_PT  = 32'h6565_6877;
    localparam logic [31:0] TV_CT  = 32'hC69B_E9BB;

    logic clk;
    logic reset;
    simon_round_ctrl_if bus ();

    simon_round_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned tests_run = 0;
    int unsigned failures  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] dut_out;

    assign dut_out = {bus.crypt_out[0], bus.crypt_out[1], bus.crypt_out[2], bus.crypt_out[3]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: straight SIMON 32/64 from the cipher definition
    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ffun(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic [31:0] model_cipher(input logic [63:0] key, input logic [31:0] blk, input bit do_enc);
        logic [15:0] k [32];
        logic [15:0] x, y, t, tmp;
        for (int j = 0; j < 4; j++) k[j] = key[16*j +: 16];
        for (int i = 0; i < 28; i++) begin
            t = rotl(k[i+3], 13) ^ k[i+1];
            k[i+4] = 16'hFFFC ^ k[i] ^ t ^ rotl(t, 15) ^ {15'd0, Z0[61-i]};
        end
        x = blk[31:16];
        y = blk[15:0];
        if (do_enc) begin
            for (int r = 0; r < 32; r++) begin
                tmp = x;
                x = y ^ ffun(x) ^ k[r];
                y = tmp;
            end
        end else begin
            for (int r = 31; r >= 0; r--) begin
                tmp = y;
                y = x ^ ffun(y) ^ k[r];
                x = tmp;
            end
        end
        return {x, y};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_inputs(input logic [63:0] key, input logic [31:0] text, input logic mode);
        for (int j = 0; j < 8; j++) bus.k_in[j] = key[63-8*j -: 8];
        for (int j = 0; j < 4; j++) bus.text_in[j] = text[31-8*j -: 8];
        bus.cryp_decryp = mode;
    endtask

    // One operation: pulse start, scramble inputs, wait for result_ready
    task automatic apply_stimulus(input logic [63:0] key, input logic [31:0] text, input logic mode,
                                  input int stray_at, input bit timed, input logic [31:0] expected);
        logic [31:0] held;
        int n;
        bit done;
        held = dut_out;
        @(negedge clk);
        set_inputs(key, text, mode);
        bus.start = 1'b1;
        exp_q.push_back(expected);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        set_inputs({$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)));
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            if (n == stray_at) begin
                set_inputs({$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)));
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
            if (bus.result_ready) begin
                done = 1'b1;
            end else if (timed) begin
                check_output("busy_in_flight", {30'd0, bus.busy, bus.result_ready}, 32'd2);
                check_output("hold_out", dut_out, held);
            end
        end
        if (!done) begin
            check_output("result_timeout", 32'(n), 32'd60);
            exp_q.delete();
        end else if (timed) begin
            check_output("latency", 32'(n), 32'd60);
            check_output("busy_done", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    // Monitor: compare crypt_out against the queued expectation on each new result
    initial begin
        logic prev_ready;
        logic [31:0] e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.result_ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_result", dut_out, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check_output("result", dut_out, e);
                end
            end
            prev_ready = bus.result_ready;
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: run did not finish, time %0t limit 1500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomised round trips
    initial begin
        logic [63:0] key;
        logic [31:0] pt, ct;

        reset = 1'b0;
        bus.start = 1'b0;
        set_inputs(64'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_flags", {30'd0, bus.busy, bus.result_ready}, 32'd0);
        check_output("reset_out", dut_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus(TV_KEY, TV_PT, 1'b1, -1, 1'b1, TV_CT);
        apply_stimulus(TV_KEY, TV_PT, 1'b1, 20, 1'b1, TV_CT);

        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            check_output("done_hold", {bus.result_ready, bus.busy, dut_out[29:0]}, {2'b10, TV_CT[29:0]});
        end
        apply_stimulus(TV_KEY, TV_CT, 1'b0, -1, 1'b1, TV_PT);

        @(negedge clk);
        set_inputs(TV_KEY, TV_PT, 1'b1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (38) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("abort_flags", {30'd0, bus.busy, bus.result_ready}, 32'd0);
        check_output("abort_out", dut_out, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("after_abort_idle", {30'd0, bus.busy, bus.result_ready}, 32'd0);
        apply_stimulus(TV_KEY, TV_PT, 1'b1, -1, 1'b1, TV_CT);

        for (int p = 0; p < 200; p++) begin
            key = {$urandom, $urandom};
            pt  = $urandom;
            ct  = model_cipher(key, pt, 1'b1);
            apply_stimulus(key, pt, 1'b1, -1, 1'b0, ct);
            apply_stimulus(key, ct, 1'b0, -1, 1'b0, pt);
        end

        @(negedge clk);
        #1;
        check_output("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
